sipo_page_ctrl: RTL

Ping-pong controller for the 1 KiB bit-addressable SIPO buffer. It packs an incoming serial bit stream from the bubble read path into one 512-byte bank while the other bank is drained byte-wise by the USB-side consumer. It drives all write and read control pins of the SIPO buffer and tracks bank ownership with full/empty flags. Overflow occurs when the serial stream outruns the consumer; overflow is flagged and never corrupts a full bank.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_rd_seq.sv | 89 ++++++++
 rtl/sipo_page_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO ping-pong page controller.
//   - Read-side sequencer state encoding.
//   - SIPO buffer geometry: bank size and address widths.
package sipo_pkg;

  localparam int unsigned SIPO_BANK_BYTES = 512;
  localparam int unsigned SIPO_WRADDR_W   = 13;  // {bank, byte[8:0], bit[2:0]}
  localparam int unsigned SIPO_RDADDR_W   = 10;  // {bank, byte[8:0]}

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_DELIV = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sipo_rd_seq.sv
// Read sequencer: drains the read bank byte-wise on consumer request.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_page_full     read bank holds a complete page
//   i_rb            current read bank
//   i_req_n         consumer byte request (low active, only honoured in R_IDLE)
//   i_rd_data       SIPO read data, valid the cycle after the read clock enable
//   o_rd_addr       SIPO read address {bank, byte}
//   o_rd_clken_n    SIPO read clock enable (low active)
//   o_byte          delivered byte
//   o_byte_valid    one-cycle pulse with o_byte
//   o_page_done     one-cycle pulse with the last byte of a page
//   o_release       one-cycle pulse: read bank fully drained, hand it back
module sipo_rd_seq
  import sipo_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = SIPO_BANK_BYTES
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_page_full,
  input  logic                     i_rb,
  input  logic                     i_req_n,
  input  logic [7:0]               i_rd_data,
  output logic [SIPO_RDADDR_W-1:0] o_rd_addr,
  output logic                     o_rd_clken_n,
  output logic [7:0]               o_byte,
  output logic                     o_byte_valid,
  output logic                     o_page_done,
  output logic                     o_release
);

  rd_state_e   r_state;
  rd_state_e   w_state_nxt;
  logic [8:0]  r_ridx;
  logic [7:0]  r_byte;
  logic        w_last;

  assign w_last    = (r_ridx == 9'(PAGE_BYTES - 1));
  assign o_rd_addr = {i_rb, r_ridx};
  assign o_byte    = r_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= R_IDLE;
      r_ridx  <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // RAM output is valid during R_WAIT; capture it on the edge into R_DELIV.
      if (r_state == R_WAIT) begin
        r_byte <= i_rd_data;
      end
      if (r_state == R_DELIV) begin
        r_ridx <= w_last ? '0 : r_ridx + 9'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_rd_clken_n = 1'b1;
    o_byte_valid = 1'b0;
    o_page_done  = 1'b0;
    o_release    = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (!i_req_n && i_page_full) begin
          w_state_nxt = R_ISSUE;
        end
      end
      R_ISSUE: begin
        o_rd_clken_n = 1'b0;
        w_state_nxt  = R_WAIT;
      end
      R_WAIT: begin
        w_state_nxt = R_DELIV;
      end
      R_DELIV: begin
        o_byte_valid = 1'b1;
        o_page_done  = w_last;
        o_release    = w_last;
        w_state_nxt  = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: rtl/sipo_page_ctrl.sv
// Ping-pong controller for the 1 KiB bit-addressable SIPO buffer.
// Packs the serial bit stream into the write bank while the read bank is
// drained byte-wise; tracks bank ownership with per-bank full flags.
// Ports:
//   MCLK, nRESET                   clock, async active-low reset
//   BITIN, nBITINSTB               serial bit and its strobe (low active)
//   nPAGESTART                     restart current write bank at bit 0
//   nCLROVF                        clear OVERFLOW
//   nSIPOWREN, nSIPOWRCLKEN        SIPO write enables (low active)
//   SIPOWRADDR, SIPOWRDATA         SIPO write address {bank,byte,bit} / data
//   SIPORDADDR, nSIPORDCLKEN       SIPO read address {bank,byte} / clock enable
//   SIPORDDATA                     SIPO read data
//   nBYTEREQ                       consumer byte request
//   BYTEOUT, BYTEVALID, PAGEDONE   delivered byte, valid pulse, last-of-page
//   PAGEREADY                      read bank full
//   WRSTALL                        write bank full, incoming bits dropped
//   OVERFLOW                       sticky dropped-bit flag
module sipo_page_ctrl
  import sipo_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = SIPO_BANK_BYTES
) (
  input  logic                     MCLK,
  input  logic                     nRESET,
  input  logic                     BITIN,
  input  logic                     nBITINSTB,
  input  logic                     nPAGESTART,
  input  logic                     nCLROVF,
  output logic                     nSIPOWREN,
  output logic [SIPO_WRADDR_W-1:0] SIPOWRADDR,
  output logic                     SIPOWRDATA,
  output logic                     nSIPOWRCLKEN,
  output logic [SIPO_RDADDR_W-1:0] SIPORDADDR,
  input  logic [7:0]               SIPORDDATA,
  output logic                     nSIPORDCLKEN,
  input  logic                     nBYTEREQ,
  output logic [7:0]               BYTEOUT,
  output logic                     BYTEVALID,
  output logic                     PAGEREADY,
  output logic                     PAGEDONE,
  output logic                     WRSTALL,
  output logic                     OVERFLOW
);

  localparam logic [11:0] LAST_BIT = 12'(PAGE_BYTES * 8 - 1);

  logic                     r_wb;
  logic                     r_rb;
  logic [1:0]               r_full;
  logic [11:0]              r_wcnt;
  logic                     r_wren_n;
  logic [SIPO_WRADDR_W-1:0] r_wraddr;
  logic                     r_wrdata;
  logic                     r_ovf;

  logic                     w_strb;
  logic                     w_wfull;
  logic                     w_wr;
  logic                     w_drop;
  logic [11:0]              w_wcnt_eff;
  logic                     w_set;
  logic                     w_release;
  logic [1:0]               w_full_nxt;

  assign w_strb     = !nBITINSTB;
  assign w_wfull    = r_full[r_wb];
  assign w_wr       = w_strb && !w_wfull;
  assign w_drop     = w_strb && w_wfull;
  // A page restart coincident with a strobe places that bit at bit 0.
  assign w_wcnt_eff = !nPAGESTART ? '0 : r_wcnt;
  assign w_set      = w_wr && (w_wcnt_eff == LAST_BIT);

  // Set and release always target different banks, so both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rb] = 1'b0;
    if (w_set)     w_full_nxt[r_wb] = 1'b1;
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_wb     <= 1'b0;
      r_rb     <= 1'b0;
      r_full   <= '0;
      r_wcnt   <= '0;
      r_wren_n <= 1'b1;
      r_wraddr <= '0;
      r_wrdata <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_full   <= w_full_nxt;
      r_wren_n <= !w_wr;
      if (w_wr) begin
        r_wraddr <= {r_wb, w_wcnt_eff};
        r_wrdata <= BITIN;
        r_wcnt   <= w_set ? '0 : w_wcnt_eff + 12'd1;
      end else if (!nPAGESTART && !w_wfull) begin
        r_wcnt <= '0;
      end
      if (w_set)     r_wb <= ~r_wb;
      if (w_release) r_rb <= ~r_rb;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (!nCLROVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  sipo_rd_seq #(
    .PAGE_BYTES(PAGE_BYTES)
  ) u_rd_seq (
    .i_clk        (MCLK),
    .i_rst_n      (nRESET),
    .i_page_full  (r_full[r_rb]),
    .i_rb         (r_rb),
    .i_req_n      (nBYTEREQ),
    .i_rd_data    (SIPORDDATA),
    .o_rd_addr    (SIPORDADDR),
    .o_rd_clken_n (nSIPORDCLKEN),
    .o_byte       (BYTEOUT),
    .o_byte_valid (BYTEVALID),
    .o_page_done  (PAGEDONE),
    .o_release    (w_release)
  );

  assign nSIPOWREN    = r_wren_n;
  assign nSIPOWRCLKEN = r_wren_n;
  assign SIPOWRADDR   = r_wraddr;
  assign SIPOWRDATA   = r_wrdata;
  assign PAGEREADY    = r_full[r_rb];
  assign WRSTALL      = r_full[r_wb];
  assign OVERFLOW     = r_ovf;

endmodule
